// File: rtl/seq_detector_1011.sv
// Moore detector for the serial pattern 1011 (MSB first) with a registered detect pulse and a saturating match counter.
// Define SEQ_DET_OVERLAP_EN to let the tail of one match start the next; leave it undefined for non-overlapping detection.
module seq_detector_1011 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             count_clr,
  output logic             detect,
  output logic [CNT_W-1:0] match_count,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_1    = 3'd1,
    S_10   = 3'd2,
    S_101  = 3'd3,
    S_1011 = 3'd4
  } state_t;

  state_t state;
  logic   hit;
  logic   illegal;

  function automatic state_t next_state(input state_t s, input logic b);
    case (s)
      S_IDLE:  return b ? S_1    : S_IDLE;
      S_1:     return b ? S_1    : S_10;
      S_10:    return b ? S_101  : S_IDLE;
      S_101:   return b ? S_1011 : S_10;
`ifdef SEQ_DET_OVERLAP_EN
      S_1011:  return b ? S_1    : S_10;
`else
      S_1011:  return b ? S_1    : S_IDLE;
`endif
      default: return S_IDLE;
    endcase
  endfunction

  // Unreachable codes 5-7 recover to idle even while the input is stalled.
  assign illegal = (state > S_1011);
  assign hit     = din_valid && (next_state(state, din) == S_1011);
  assign state_o = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      detect      <= 1'b0;
      match_count <= '0;
    end else begin
      if (din_valid || illegal)
        state <= next_state(state, din);
      detect <= hit;
      if (count_clr)
        match_count <= '0;
      else if (hit && (match_count != {CNT_W{1'b1}}))
        match_count <= match_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detector_1011.sv
// Randomized and directed bench for seq_detector_1011 against a bit-window reference model.
// Two instances share stimulus: default CNT_W=8 and CNT_W=2 for counter saturation.
module tb_seq_detector_1011;

  logic       clk = 1'b0;
  logic       reset, din, din_valid, count_clr;
  logic       detect, detect2;
  logic [7:0] match_count;
  logic [1:0] match_count2;
  logic [2:0] state_o, state2;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef SEQ_DET_OVERLAP_EN
  localparam int OVL_CNT = 2;
`else
  localparam int OVL_CNT = 1;
`endif

  seq_detector_1011 dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .count_clr(count_clr),
    .detect(detect), .match_count(match_count), .state_o(state_o)
  );

  seq_detector_1011 #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .count_clr(count_clr),
    .detect(detect2), .match_count(match_count2), .state_o(state2)
  );

  always #5 clk = ~clk;

  // Model: the state is the length of the longest tail of the accepted bits that is a prefix of 1011.
  bit win[$];
  bit clear_next;
  int m_state, m_cnt8, m_cnt2;
  bit m_det;
  bit pat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  function automatic int prefix_len();
    for (int k = 4; k >= 1; k--) begin
      if (win.size() >= k) begin
        bit ok = 1'b1;
        for (int i = 0; i < k; i++)
          if (win[win.size() - k + i] != pat[i]) ok = 1'b0;
        if (ok) return k;
      end
    end
    return 0;
  endfunction

  task automatic model_edge(input bit d, input bit v, input bit c, input bit r);
    if (!r) begin
      win.delete();
      clear_next = 1'b0;
      m_state = 0; m_det = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      m_det = 1'b0;
      if (v) begin
        if (clear_next) begin
          win.delete();
          clear_next = 1'b0;
        end
        win.push_back(d);
        if (win.size() > 4) void'(win.pop_front());
        m_state = prefix_len();
        if (m_state == 4) begin
          m_det = 1'b1;
`ifndef SEQ_DET_OVERLAP_EN
          clear_next = 1'b1;
`endif
        end
      end
      if (c) begin
        m_cnt8 = 0; m_cnt2 = 0;
      end else if (m_det) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit d, input bit v, input bit c = 1'b0, input bit r = 1'b1);
    @(negedge clk);
    reset = r; din = d; din_valid = v; count_clr = c;
    @(posedge clk);
    model_edge(d, v, c, r);
    #1;
    chk("detect",  32'(detect),       32'(m_det));
    chk("count8",  32'(match_count),  32'(m_cnt8));
    chk("state",   32'(state_o),      32'(m_state));
    chk("detect2", 32'(detect2),      32'(m_det));
    chk("count2",  32'(match_count2), 32'(m_cnt2));
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic feed_1011();
    step(1, 1); step(0, 1); step(1, 1); step(1, 1);
  endtask

  initial begin
    reset = 1'b0; din = 1'b0; din_valid = 1'b0; count_clr = 1'b0;

    // reset holds everything at zero regardless of valid data
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      chk("rst_det", 32'(detect), 0);
      chk("rst_cnt", 32'(match_count), 0);
      chk("rst_state", 32'(state_o), 0);
    end

    // overlapping stream 1011011
    do_reset();
    step(1, 1); step(0, 1); step(1, 1); step(1, 1);
    chk("ovl_det4", 32'(detect), 1);
    step(0, 1); step(1, 1); step(1, 1);
    chk("ovl_cnt", 32'(match_count), 32'(OVL_CNT));

    // stall in S_10
    do_reset();
    step(1, 1); step(0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0);
      chk("stall_state", 32'(state_o), 2);
      chk("stall_det", 32'(detect), 0);
    end
    step(1, 1);
    chk("stall_det3", 32'(detect), 0);
    step(1, 1);
    chk("stall_det4", 32'(detect), 1);
    chk("stall_cnt", 32'(match_count), 1);
    step(0, 0);
    chk("pulse_once", 32'(detect), 0);
    chk("hold_1011", 32'(state_o), 4);

    // saturation of the narrow counter
    do_reset();
    for (int i = 0; i < 5; i++) begin
      feed_1011();
      chk("sat_det", 32'(detect2), 1);
      chk("sat_cnt", 32'(match_count2), 32'((i + 1 > 3) ? 3 : i + 1));
    end

    // reset mid-pattern
    do_reset();
    step(1, 1); step(0, 1); step(1, 1);
    chk("mid_state3", 32'(state_o), 3);
    step(0, 1, 0, 0);
    chk("mid_state0", 32'(state_o), 0);
    step(1, 1);
    chk("mid_state1", 32'(state_o), 1);
    chk("mid_det", 32'(detect), 0);
    chk("mid_cnt", 32'(match_count), 0);

    // clear colliding with a detection
    do_reset();
    for (int i = 0; i < 5; i++) feed_1011();
    chk("clr_pre", 32'(match_count), 5);
    step(1, 1); step(0, 1); step(1, 1); step(1, 1, 1);
    chk("clr_det", 32'(detect), 1);
    chk("clr_cnt", 32'(match_count), 0);
    step(0, 0);
    chk("clr_det_off", 32'(detect), 0);
    feed_1011();
    chk("clr_next", 32'(match_count), 1);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) != 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detector_1011.md
Name: seq_detector_1011

Overview:
- Serial pattern detector that consumes the registered bit stream produced by the single-bit D flip-flop stage (its q output drives din here).
- Moore FSM recognises the pattern 1011, MSB first: the first bit received is the leftmost bit of the pattern.
- Produces a one-cycle detect pulse and a saturating match counter.
- Bits advance only on cycles where din_valid is high, so the upstream stage may stall.

Parameters:
- CNT_W, 8, width of match_count; the counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- din  input  1  serial data bit, from the upstream flip-flop q.
- din_valid  input  1  din is consumed on a rising edge only when this is 1.
- count_clr  input  1  synchronous clear of match_count.
- detect  output  1  one-cycle pulse when the pattern completes.
- match_count  output  CNT_W  number of detections since reset or clear; saturating.
- state_o  output  3  current FSM state encoding, for debug.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=S_IDLE, detect=0, match_count=0, state_o=3'd0.
  - Reset overrides every other input, including count_clr and din_valid.
- State encoding: S_IDLE=0, S_1=1, S_10=2, S_101=3, S_1011=4; codes 5-7 are illegal and go to S_IDLE on the next edge.
- Transitions occur only on edges with din_valid=1. With din_valid=0 the state holds and din is ignored.
- Transition table, given as (din=0 -> next, din=1 -> next):
  - S_IDLE: 0 -> S_IDLE, 1 -> S_1
  - S_1: 0 -> S_10, 1 -> S_1
  - S_10: 0 -> S_IDLE, 1 -> S_101
  - S_101: 0 -> S_10, 1 -> S_1011
  - S_1011: depends on SEQ_DET_OVERLAP_EN; see Optional Feature.
- detect:
  - Registered. Set to 1 on the edge where din_valid=1 and next state is S_1011; 0 on all other edges.
  - Latency: high for exactly the one cycle following the edge that samples the 4th pattern bit.
  - Never stays high for more than one cycle, even if the FSM remains in S_1011 while din_valid=0.
- match_count:
  - Increments by 1 on the same edge that sets detect.
  - Holds at 2^CNT_W-1 once reached; no wrap-around.
- count_clr=1 at an edge:
  - match_count becomes 0, and clear wins over a simultaneous detection (that event is not counted).
  - detect still pulses normally; FSM state is unaffected.
- Reset mid-pattern discards all partial progress; the next bits are matched from S_IDLE.
- state_o mirrors the state register; there is no extra latency.

Optional Feature:
- Macro: SEQ_DET_OVERLAP_EN.
- Defined (overlapping detection):
  - From S_1011: din=0 -> S_10, din=1 -> S_1.
  - The trailing bits of one match can begin the next match.
- Not defined (non-overlapping detection):
  - From S_1011: din=0 -> S_IDLE, din=1 -> S_1, i.e. the same as S_IDLE.
  - Bits belonging to a completed match are never reused.
- All other transitions, detect and counter behaviour are identical in both builds.

Test Plan:
- Overlap stream: reset low 1 cycle, then din_valid=1 every cycle, din = 1,0,1,1,0,1,1.
  - With SEQ_DET_OVERLAP_EN: detect pulses after the 4th and 7th bits; match_count=2.
  - Without it: one pulse after the 4th bit only; match_count=1.
- Stall handling: din = 1, 0; then din_valid=0 for 3 cycles with din=1; then valid din = 1, 1.
  - state_o holds at 2 during the gap.
  - detect stays 0 until one pulse after the final bit; match_count=1.
- Saturation: CNT_W=2, feed 1011 five times, non-overlapping and back to back.
  - match_count reads 1,2,3,3,3; detect pulses all 5 times.
- Mid-pattern reset: din = 1,0,1 (state_o=3), then reset=0 for one edge, then din=1.
  - state_o=0 after the reset edge and 1 after the din=1 edge.
  - No detect; match_count=0.
- Clear collision: with match_count=5, assert count_clr on the same edge that completes 1011.
  - detect=1 for one cycle; match_count=0 afterwards.
  - The next 1011 gives match_count=1.
- Reset values: hold reset=0 with din_valid=1 and din=1 for 3 edges.
  - detect=0, match_count=0, state_o=0 throughout.
